// File: rtl/fpmult_round_stage_if.sv
// Handshake and data bundle between the normalizer, the round stage and the packing stage.
// master drives operands and OutReady; slave is the round stage itself.
interface fpmult_round_stage_if;
   logic        InValid;
   logic        InReady;
   logic [24:0] NormM;
   logic        Sticky;
   logic [8:0]  NormE;
   logic        SgnIn;
   logic        OutValid;
   logic        OutReady;
   logic [23:0] RoundM;
   logic [8:0]  RoundE;
   logic        Sgn;

   modport master (
      output InValid, NormM, Sticky, NormE, SgnIn, OutReady,
      input  InReady, OutValid, RoundM, RoundE, Sgn
   );

   modport slave (
      input  InValid, NormM, Sticky, NormE, SgnIn, OutReady,
      output InReady, OutValid, RoundM, RoundE, Sgn
   );
endinterface

// File: rtl/fpmult_round_stage.sv
// Round-to-nearest-even stage of the FP multiplier; 1-cycle latency, 1 result/cycle.
// Two-entry skid buffer: InReady is registered and drops only once the skid entry holds data.
module fpmult_round_stage (
   input  logic                  clk,
   input  logic                  rst_n,
   fpmult_round_stage_if.slave   bus
);

   typedef struct packed {
      logic [23:0] mant;
      logic [8:0]  expo;
      logic        sgn;
   } result_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} bufState_t;

   bufState_t   state;
   result_t     mainReg;
   result_t     skidReg;
   result_t     rounded;
   logic        inReadyReg;
   logic        outValidReg;
   logic        roundUp;
   logic [24:0] sum;
   logic        inXfer;
   logic        outXfer;

   // A carry out of the mantissa can only come from all-ones + 1, so the
   // shifted result is always 1.000...; bit 8 of the exponent wraps freely.
   always_comb begin
      roundUp      = bus.NormM[0] & (bus.Sticky | bus.NormM[1]);
      sum          = {1'b0, bus.NormM[24:1]} + {24'd0, roundUp};
      rounded.mant = sum[23:0];
      rounded.expo = bus.NormE;
      rounded.sgn  = bus.SgnIn;
      if (sum[24]) begin
         rounded.mant = sum[24:1];
         rounded.expo = bus.NormE + 9'd1;
      end
   end

   assign inXfer  = bus.InValid & inReadyReg;
   assign outXfer = outValidReg & bus.OutReady;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         mainReg     <= '0;
         skidReg     <= '0;
         inReadyReg  <= 1'b1;
         outValidReg <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (inXfer) begin
                  mainReg     <= rounded;
                  outValidReg <= 1'b1;
                  state       <= ONE;
               end
            end
            ONE: begin
               if (inXfer && !outXfer) begin
                  skidReg    <= rounded;
                  inReadyReg <= 1'b0;
                  state      <= FULL;
               end else if (inXfer && outXfer) begin
                  mainReg <= rounded;
               end else if (outXfer) begin
                  outValidReg <= 1'b0;
                  state       <= EMPTY;
               end
            end
            FULL: begin
               if (outXfer) begin
                  mainReg    <= skidReg;
                  inReadyReg <= 1'b1;
                  state      <= ONE;
               end
            end
            default: begin
               state       <= EMPTY;
               outValidReg <= 1'b0;
               inReadyReg  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.InReady  = inReadyReg;
   assign bus.OutValid = outValidReg;
   assign bus.RoundM   = mainReg.mant;
   assign bus.RoundE   = mainReg.expo;
   assign bus.Sgn      = mainReg.sgn;

endmodule
